lab5_3_seq: RTL and testbench



---
 rtl/lab5_3_seq.sv | 141 ++++++++++++++
 tb/tb_lab5_3_seq.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lab5_3_seq.sv
// rtl/lab5_3_seq.sv - round-robin two-requester arbiter with bit-serial write into a four-cell bank
module lab5_3_seq (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       ReqA,
    input  logic [3:0] DataA,
    input  logic       ReqB,
    input  logic [3:0] DataB,
    output logic       GntA,
    output logic       GntB,
    output logic       Busy,
    output logic       DoneOut,
    output logic       D,
    output logic [3:0] En,
    output logic       Qa,
    output logic       Qb,
    output logic       Qc,
    output logic       Qd
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] idx_q, idx_d;
    // last_q / owner_q: 0 = requester A, 1 = requester B
    logic       last_q, last_d;
    logic       owner_q, owner_d;
    logic [3:0] word_q, word_d;
    logic [3:0] bank_q, bank_d;
    logic       pick_b;

    // State, index, arbitration pointer, owner and latched word registers
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= S_IDLE;
            idx_q   <= 2'd0;
            last_q  <= 1'b1;
            owner_q <= 1'b0;
            word_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            word_q  <= word_d;
        end
    end

    // Next-state logic: grant in IDLE, walk four cells in WRITE, one-cycle DONE
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        last_d  = last_q;
        owner_d = owner_q;
        word_d  = word_q;
        // B wins when it is the only requester, or on a tie when A was served last
        pick_b  = ReqB && (!ReqA || !last_q);
        unique case (state_q)
            S_IDLE: begin
                if (ReqA || ReqB) begin
                    state_d = S_WRITE;
                    idx_d   = 2'd0;
                    owner_d = pick_b;
                    last_d  = pick_b;
                    word_d  = pick_b ? DataB : DataA;
                end
            end
            S_WRITE: begin
                idx_d = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                idx_d   = 2'd0;
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = 2'd0;
            end
        endcase
    end

    // Output decode: grant held through WRITE and DONE, serial data only in WRITE
    always_comb begin
        GntA    = 1'b0;
        GntB    = 1'b0;
        Busy    = 1'b0;
        DoneOut = 1'b0;
        D       = 1'b0;
        En      = 4'b0000;
        unique case (state_q)
            S_WRITE: begin
                GntA = !owner_q;
                GntB = owner_q;
                Busy = 1'b1;
                D    = word_q[idx_q];
                En   = 4'b0001 << idx_q;
            end
            S_DONE: begin
                GntA    = !owner_q;
                GntB    = owner_q;
                DoneOut = 1'b1;
            end
            default: begin
                GntA = 1'b0;
                GntB = 1'b0;
            end
        endcase
    end

    // Cell update: only the enabled cell samples D, all others hold
    always_comb begin
        bank_d = bank_q;
        for (int k = 0; k < 4; k++) begin
            if (En[k]) begin
                bank_d[k] = D;
            end
        end
    end

    // Storage bank register; reset clears partially written words too
    always_ff @(posedge Clock) begin
        if (Reset) begin
            bank_q <= 4'd0;
        end else begin
            bank_q <= bank_d;
        end
    end

    assign Qa = bank_q[0];
    assign Qb = bank_q[1];
    assign Qc = bank_q[2];
    assign Qd = bank_q[3];

endmodule

// File: tb/tb_lab5_3_seq.sv
// tb/tb_lab5_3_seq.sv - directed self-checking bench for lab5_3_seq
module tb_lab5_3_seq;

    logic       Clock;
    logic       Reset;
    logic       ReqA;
    logic [3:0] DataA;
    logic       ReqB;
    logic [3:0] DataB;
    logic       GntA;
    logic       GntB;
    logic       Busy;
    logic       DoneOut;
    logic       D;
    logic [3:0] En;
    logic       Qa;
    logic       Qb;
    logic       Qc;
    logic       Qd;
    logic [3:0] q;

    int checks;
    int errors;

    assign q = {Qd, Qc, Qb, Qa};

    lab5_3_seq dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .ReqA    (ReqA),
        .DataA   (DataA),
        .ReqB    (ReqB),
        .DataB   (DataB),
        .GntA    (GntA),
        .GntB    (GntB),
        .Busy    (Busy),
        .DoneOut (DoneOut),
        .D       (D),
        .En      (En),
        .Qa      (Qa),
        .Qb      (Qb),
        .Qc      (Qc),
        .Qd      (Qd)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic test_reset();
        Reset = 1'b1;
        ReqA  = 1'b0;
        ReqB  = 1'b0;
        DataA = 4'd0;
        DataB = 4'd0;
        repeat (2) @(negedge Clock);
        checks++;
        if ({GntA, GntB, Busy, DoneOut, D} !== 5'b00000) begin
            errors++;
            $display("FAIL reset_ctrl got %b want 00000", {GntA, GntB, Busy, DoneOut, D});
        end
        checks++;
        if (En !== 4'b0000) begin
            errors++;
            $display("FAIL reset_en got %b want 0000", En);
        end
        checks++;
        if (q !== 4'b0000) begin
            errors++;
            $display("FAIL reset_bank got %b want 0000", q);
        end
        Reset = 1'b0;
    endtask

    task automatic test_single_a();
        logic [3:0] word;
        word  = 4'b1011;
        ReqA  = 1'b1;
        DataA = word;
        for (int k = 0; k < 4; k++) begin
            @(negedge Clock);
            checks++;
            if (En !== (4'b0001 << k)) begin
                errors++;
                $display("FAIL single_en%0d got %b want %b", k, En, 4'b0001 << k);
            end
            checks++;
            if (D !== word[k]) begin
                errors++;
                $display("FAIL single_d%0d got %b want %b", k, D, word[k]);
            end
            checks++;
            if ({GntA, GntB, Busy, DoneOut} !== 4'b1010) begin
                errors++;
                $display("FAIL single_write%0d gnta/gntb/busy/done got %b want 1010", k, {GntA, GntB, Busy, DoneOut});
            end
        end
        @(negedge Clock);
        checks++;
        if ({GntA, GntB, Busy, DoneOut} !== 4'b1001) begin
            errors++;
            $display("FAIL single_done gnta/gntb/busy/done got %b want 1001", {GntA, GntB, Busy, DoneOut});
        end
        checks++;
        if (En !== 4'b0000 || D !== 1'b0) begin
            errors++;
            $display("FAIL single_done_en got en=%b d=%b want en=0000 d=0", En, D);
        end
        checks++;
        if (q !== 4'b1011) begin
            errors++;
            $display("FAIL single_bank got %b want 1011", q);
        end
        ReqA = 1'b0;
        @(negedge Clock);
        checks++;
        if ({GntA, GntB, Busy, DoneOut} !== 4'b0000) begin
            errors++;
            $display("FAIL single_idle gnta/gntb/busy/done got %b want 0000", {GntA, GntB, Busy, DoneOut});
        end
    endtask

    task automatic test_round_robin();
        int         dones;
        int         both_high;
        int         bad_en;
        logic [2:0] want_owner;
        logic [3:0] want_word [3];
        want_owner   = 3'b010;
        want_word[0] = 4'b0101;
        want_word[1] = 4'b1110;
        want_word[2] = 4'b0101;
        dones     = 0;
        both_high = 0;
        bad_en    = 0;
        Reset = 1'b1;
        ReqA  = 1'b1;
        ReqB  = 1'b1;
        DataA = 4'b0101;
        DataB = 4'b1110;
        @(negedge Clock);
        Reset = 1'b0;
        for (int c = 0; c < 30 && dones < 3; c++) begin
            @(negedge Clock);
            if (GntA && GntB) both_high++;
            if (En != 4'b0000 && En != 4'b0001 && En != 4'b0010 && En != 4'b0100 && En != 4'b1000) bad_en++;
            if (DoneOut) begin
                checks++;
                if ({GntA, GntB} !== (want_owner[dones] ? 2'b01 : 2'b10)) begin
                    errors++;
                    $display("FAIL rr_owner%0d got gnta/gntb=%b want %b", dones, {GntA, GntB}, want_owner[dones] ? 2'b01 : 2'b10);
                end
                checks++;
                if (q !== want_word[dones]) begin
                    errors++;
                    $display("FAIL rr_bank%0d got %b want %b", dones, q, want_word[dones]);
                end
                dones++;
                if (dones == 3) begin
                    ReqA = 1'b0;
                    ReqB = 1'b0;
                end
            end
        end
        checks++;
        if (dones !== 3) begin
            errors++;
            $display("FAIL rr_done_count got %0d want 3", dones);
        end
        checks++;
        if (both_high !== 0 || bad_en !== 0) begin
            errors++;
            $display("FAIL rr_exclusive got both_gnt=%0d bad_en=%0d want 0 0", both_high, bad_en);
        end
        ReqA = 1'b0;
        ReqB = 1'b0;
        @(negedge Clock);
    endtask

    task automatic test_data_change();
        int width;
        width = 0;
        ReqA  = 1'b1;
        DataA = 4'b1111;
        @(negedge Clock);
        DataA = 4'b0000;
        @(negedge Clock);
        ReqA = 1'b0;
        for (int c = 0; c < 10 && !DoneOut; c++) @(negedge Clock);
        checks++;
        if (DoneOut !== 1'b1) begin
            errors++;
            $display("FAIL latch_done got %b want 1 (timeout)", DoneOut);
        end
        checks++;
        if (q !== 4'b1111) begin
            errors++;
            $display("FAIL latch_bank got %b want 1111", q);
        end
        while (DoneOut && width < 5) begin
            width++;
            @(negedge Clock);
        end
        checks++;
        if (width !== 1) begin
            errors++;
            $display("FAIL latch_done_width got %0d want 1", width);
        end
    endtask

    task automatic test_reset_mid();
        ReqA  = 1'b1;
        DataA = 4'b0110;
        repeat (3) @(negedge Clock);
        ReqA = 1'b0;
        checks++;
        if (En !== 4'b0100) begin
            errors++;
            $display("FAIL mid_pre_en got %b want 0100", En);
        end
        Reset = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;
        checks++;
        if (q !== 4'b0000 || En !== 4'b0000) begin
            errors++;
            $display("FAIL mid_abort got bank=%b en=%b want 0000 0000", q, En);
        end
        checks++;
        if ({GntA, GntB, Busy, DoneOut} !== 4'b0000) begin
            errors++;
            $display("FAIL mid_abort_ctrl got %b want 0000", {GntA, GntB, Busy, DoneOut});
        end
        ReqB  = 1'b1;
        DataB = 4'b1010;
        @(negedge Clock);
        ReqB = 1'b0;
        for (int c = 0; c < 10 && !DoneOut; c++) @(negedge Clock);
        checks++;
        if (DoneOut !== 1'b1 || {GntA, GntB} !== 2'b01) begin
            errors++;
            $display("FAIL mid_after got done=%b gnta/gntb=%b want 1 01", DoneOut, {GntA, GntB});
        end
        checks++;
        if (q !== 4'b1010) begin
            errors++;
            $display("FAIL mid_after_bank got %b want 1010", q);
        end
        @(negedge Clock);
    endtask

    task automatic test_idle_hold();
        int bad;
        bad   = 0;
        ReqB  = 1'b1;
        DataB = 4'b1001;
        @(negedge Clock);
        ReqB = 1'b0;
        for (int c = 0; c < 10 && !DoneOut; c++) @(negedge Clock);
        checks++;
        if (q !== 4'b1001) begin
            errors++;
            $display("FAIL idle_preload got %b want 1001", q);
        end
        DataA = 4'b0110;
        DataB = 4'b0110;
        for (int c = 0; c < 20; c++) begin
            @(negedge Clock);
            if (q !== 4'b1001 || En !== 4'b0000 || DoneOut !== 1'b0 || Busy !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL idle_hold got %0d disturbed cycles want 0 (bank=%b)", bad, q);
        end
    endtask

    task automatic test_latency();
        ReqB  = 1'b1;
        DataB = 4'b0011;
        @(negedge Clock);
        checks++;
        if ({GntB, Busy} !== 2'b11) begin
            errors++;
            $display("FAIL lat_e0 got gntb/busy=%b want 11", {GntB, Busy});
        end
        for (int k = 1; k < 4; k++) begin
            @(negedge Clock);
            checks++;
            if ({GntB, Busy, DoneOut} !== 3'b110) begin
                errors++;
                $display("FAIL lat_e%0d got gntb/busy/done=%b want 110", k, {GntB, Busy, DoneOut});
            end
        end
        @(negedge Clock);
        ReqB = 1'b0;
        checks++;
        if ({GntB, Busy, DoneOut} !== 3'b101) begin
            errors++;
            $display("FAIL lat_e4 got gntb/busy/done=%b want 101", {GntB, Busy, DoneOut});
        end
        checks++;
        if (q !== 4'b0011) begin
            errors++;
            $display("FAIL lat_bank got %b want 0011", q);
        end
        @(negedge Clock);
        checks++;
        if ({GntB, Busy, DoneOut} !== 3'b000) begin
            errors++;
            $display("FAIL lat_e5 got gntb/busy/done=%b want 000", {GntB, Busy, DoneOut});
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single_a();
        test_round_robin();
        test_data_change();
        test_reset_mid();
        test_idle_hold();
        test_latency();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
